// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock,
// WIDTH steps per signed product, with valid/ready handshakes on both sides.
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH:0]  m;
  logic [WIDTH:0]  acc;
  logic [WIDTH-1:0] q;
  logic            q_1;
  logic [CW-1:0]   cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             last;

  // One Booth step: conditional add/sub of M, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    // NOTE: default first so every path assigns sum; otherwise a latch is inferred.
    sum = acc;
    unique case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
  end

  assign last     = (cnt == CW'(WIDTH - 1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so all registers update from pre-edge values.
      state     <= IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= {a[WIDTH-1], a};
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          q_1 <= q[0];
          cnt <= cnt + CW'(1);
          if (last) begin
            // The extra accumulator bit only absorbs the -2^(WIDTH-1) overflow.
            out       <= {acc_next[WIDTH-1:0], q_next};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
